// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the two-master arbiter slice.
package wb_pkg;

    localparam int unsigned WB_AW    = 32;
    localparam int unsigned WB_DW    = 32;
    localparam int unsigned WB_SEL_W = WB_DW / 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

endpackage : wb_pkg

// File: rtl/wb_arbiter_2m_if.sv
// One Wishbone B4 classic link; master modport drives the request side.
interface wb_arbiter_2m_if
    import wb_pkg::*;
#(
    parameter int unsigned AW = WB_AW,
    parameter int unsigned DW = WB_DW
);

    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );

endinterface : wb_arbiter_2m_if

// File: rtl/wb_watchdog.sv
// Bus watchdog: raises a one-cycle error after TIMEOUT-1 stalled strobe cycles.
// TIMEOUT of 0 disables the error entirely.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic busy,
    output logic wd_err
);

    localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] SAT   = {CW{1'b1}};

    logic [CW-1:0] r_cnt;

    // Error fires in the same cycle the counter sits at its limit with a stalled strobe.
    assign wd_err = EN && busy && (r_cnt == LIMIT);

    // Saturating stall counter, cleared by termination, tenure end or its own error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr || wd_err) begin
            r_cnt <= '0;
        end else if (busy && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule : wb_watchdog

// File: rtl/wb_arbiter_2m.sv
// Round-robin arbiter sharing one Wishbone master port between m0 and m1.
// Grant is held for a whole cyc tenure; hung strobes are terminated by the watchdog.
module wb_arbiter_2m
    import wb_pkg::*;
#(
    parameter int unsigned AW      = WB_AW,
    parameter int unsigned DW      = WB_DW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    wb_arbiter_2m_if.slave  m0,
    wb_arbiter_2m_if.slave  m1,
    wb_arbiter_2m_if.master s,
    output logic [1:0]      grant_o
);

    localparam int unsigned SW = DW / 8;

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic       w_wd_busy;
    logic       w_wd_clr;
    logic       w_wd_err;

    // State and last-granted registers; last=1 so m0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state: round-robin pick in IDLE, hold grant until the owner drops cyc.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            ARB_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    if (r_last) begin
                        w_state_nxt = ARB_GNT0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ARB_GNT1;
                        w_last_nxt  = 1'b1;
                    end
                end else if (m0.cyc) begin
                    w_state_nxt = ARB_GNT0;
                    w_last_nxt  = 1'b0;
                end else if (m1.cyc) begin
                    w_state_nxt = ARB_GNT1;
                    w_last_nxt  = 1'b1;
                end
            end
            ARB_GNT0: if (!m0.cyc) w_state_nxt = ARB_IDLE;
            ARB_GNT1: if (!m1.cyc) w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    // Watchdog inputs derived from the owner's request, independent of the output mux.
    always_comb begin
        w_wd_busy = 1'b0;
        case (r_state)
            ARB_GNT0: w_wd_busy = m0.cyc & m0.stb;
            ARB_GNT1: w_wd_busy = m1.cyc & m1.stb;
            default:  w_wd_busy = 1'b0;
        endcase
        w_wd_busy = w_wd_busy & ~s.ack & ~s.err;
        w_wd_clr  = (r_state == ARB_IDLE) | s.ack | s.err;
    end

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_wd_clr),
        .busy    (w_wd_busy),
        .wd_err  (w_wd_err)
    );

    // Route the owner to the shared port; the waiting master and IDLE see zeros.
    always_comb begin
        s.adr    = '0;
        s.dat_w  = '0;
        s.sel    = SW'(0);
        s.we     = 1'b0;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        m0.dat_r = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.dat_r = '0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        grant_o  = 2'b00;
        case (r_state)
            ARB_GNT0: begin
                s.adr    = m0.adr;
                s.dat_w  = m0.dat_w;
                s.sel    = m0.sel;
                s.we     = m0.we;
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                m0.dat_r = s.dat_r;
                m0.ack   = s.ack;
                m0.err   = s.err | w_wd_err;
                grant_o  = 2'b01;
            end
            ARB_GNT1: begin
                s.adr    = m1.adr;
                s.dat_w  = m1.dat_w;
                s.sel    = m1.sel;
                s.we     = m1.we;
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                m1.dat_r = s.dat_r;
                m1.ack   = s.ack;
                m1.err   = s.err | w_wd_err;
                grant_o  = 2'b10;
            end
            default: ;
        endcase
    end

endmodule : wb_arbiter_2m

// File: tb/tb_wb_arbiter_2m.sv
// Scoreboard bench for wb_arbiter_2m: directed stimulus pushes expected
// terminations; a negedge monitor pops and compares every ack/err seen by a master.
module tb_wb_arbiter_2m;
    import wb_pkg::*;

    typedef struct {
        logic        dut;
        logic        who;
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a_n;
    logic       rst_b_n;
    logic [1:0] grant_a;
    logic [1:0] grant_b;

    int   n_vec;
    int   n_err;
    exp_t q[$];

    always #5 clk = ~clk;

    wb_arbiter_2m_if #(.AW(32), .DW(32)) a_m0 ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) a_m1 ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) a_s  ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) b_m0 ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) b_m1 ();
    wb_arbiter_2m_if #(.AW(32), .DW(32)) b_s  ();

    wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(8)) u_dut_a (
        .clk     (clk),
        .reset_n (rst_a_n),
        .m0      (a_m0),
        .m1      (a_m1),
        .s       (a_s),
        .grant_o (grant_a)
    );

    wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(0)) u_dut_b (
        .clk     (clk),
        .reset_n (rst_b_n),
        .m0      (b_m0),
        .m1      (b_m1),
        .s       (b_s),
        .grant_o (grant_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic expect_term(input logic dut, input logic who, input logic ack,
                               input logic err, input logic [31:0] dat);
        exp_t e;
        e.dut = dut; e.who = who; e.ack = ack; e.err = err; e.dat = dat;
        q.push_back(e);
    endtask

    task automatic observe(input logic dut,
                           input logic m0a, input logic m0e, input logic [31:0] m0d,
                           input logic m1a, input logic m1e, input logic [31:0] m1d);
        exp_t        e;
        logic        who;
        logic        a;
        logic        er;
        logic [31:0] d;
        n_vec++;
        if ((m0a | m0e) && (m1a | m1e)) begin
            n_err++;
            $display("FAIL both_terminated dut%0d: m0 ack/err %b%b m1 ack/err %b%b", dut, m0a, m0e, m1a, m1e);
            return;
        end
        who = m1a | m1e;
        a   = who ? m1a : m0a;
        er  = who ? m1e : m0e;
        d   = who ? m1d : m0d;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_term dut%0d: m%0d ack=%b err=%b dat=%08h, expected none at %0t",
                     dut, who, a, er, d, $time);
            return;
        end
        e = q.pop_front();
        if (e.dut !== dut || e.who !== who || e.ack !== a || e.err !== er || e.dat !== d) begin
            n_err++;
            $display("FAIL term dut%0d: got m%0d ack=%b err=%b dat=%08h, expected dut%0d m%0d ack=%b err=%b dat=%08h at %0t",
                     dut, who, a, er, d, e.dut, e.who, e.ack, e.err, e.dat, $time);
        end
    endtask

    // Monitor: any termination reaching a master is checked against the queue.
    always @(negedge clk) begin
        if (a_m0.ack | a_m0.err | a_m1.ack | a_m1.err)
            observe(1'b0, a_m0.ack, a_m0.err, a_m0.dat_r, a_m1.ack, a_m1.err, a_m1.dat_r);
        if (b_m0.ack | b_m0.err | b_m1.ack | b_m1.err)
            observe(1'b1, b_m0.ack, b_m0.err, b_m0.dat_r, b_m1.ack, b_m1.err, b_m1.dat_r);
    end

    initial begin
        int errs;
        int k;
        logic owner;
        n_vec = 0;
        n_err = 0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        {a_m0.adr, a_m0.dat_w, a_m0.sel, a_m0.we, a_m0.cyc, a_m0.stb} = '0;
        {a_m1.adr, a_m1.dat_w, a_m1.sel, a_m1.we, a_m1.cyc, a_m1.stb} = '0;
        {b_m0.adr, b_m0.dat_w, b_m0.sel, b_m0.we, b_m0.cyc, b_m0.stb} = '0;
        {b_m1.adr, b_m1.dat_w, b_m1.sel, b_m1.we, b_m1.cyc, b_m1.stb} = '0;
        a_s.dat_r = 32'h5555_5555; a_s.ack = 1'b0; a_s.err = 1'b0;
        b_s.dat_r = 32'h0;         b_s.ack = 1'b0; b_s.err = 1'b0;

        // Reset values
        tick(); tick();
        chk("rst_grant",  32'(grant_a), 32'h0);
        chk("rst_s_cyc",  32'(a_s.cyc), 32'h0);
        chk("rst_s_adr",  a_s.adr, 32'h0);
        chk("rst_m0_dat", a_m0.dat_r, 32'h0);
        chk("rst_m1_ack", 32'(a_m1.ack), 32'h0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        a_s.dat_r = 32'h0;
        tick();

        // Single m0 read, slave acks two cycles after grant
        a_m0.adr = 32'h2000_0004; a_m0.we = 1'b0; a_m0.sel = 4'hF;
        a_m0.cyc = 1'b1; a_m0.stb = 1'b1;
        tick();
        chk("t1_grant", 32'(grant_a), 32'h1);
        chk("t1_s_adr", a_s.adr, 32'h2000_0004);
        chk("t1_s_cyc_stb", 32'({a_s.cyc, a_s.stb}), 32'h3);
        chk("t1_s_we", 32'(a_s.we), 32'h0);
        tick();
        tick();
        expect_term(1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        a_s.dat_r = 32'hDEAD_BEEF; a_s.ack = 1'b1;
        tick();
        a_s.ack = 1'b0; a_s.dat_r = 32'h0;
        a_m0.cyc = 1'b0; a_m0.stb = 1'b0;
        tick();
        chk("t1_idle_grant", 32'(grant_a), 32'h0);
        chk("t1_idle_s_cyc", 32'(a_s.cyc), 32'h0);

        // Simultaneous request out of reset: m0 first, m1 two cycles after m0 drops
        rst_a_n = 1'b0;
        tick();
        rst_a_n = 1'b1;
        tick();
        a_m0.adr = 32'h2000_0008; a_m0.we = 1'b0; a_m0.sel = 4'hF;
        a_m1.adr = 32'h1000_0000; a_m1.dat_w = 32'hA5A5_0001; a_m1.we = 1'b1; a_m1.sel = 4'h3;
        a_m0.cyc = 1'b1; a_m0.stb = 1'b1;
        a_m1.cyc = 1'b1; a_m1.stb = 1'b1;
        tick();
        chk("t2_grant_m0", 32'(grant_a), 32'h1);
        chk("t2_s_adr_m0", a_s.adr, 32'h2000_0008);
        expect_term(1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
        a_s.dat_r = 32'h1234_5678; a_s.ack = 1'b1;
        tick();
        a_s.ack = 1'b0;
        a_m0.cyc = 1'b0; a_m0.stb = 1'b0;
        chk("t2_hold_m0", 32'(grant_a), 32'h1);
        tick();
        chk("t2_gap_idle", 32'(grant_a), 32'h0);
        tick();
        chk("t2_grant_m1", 32'(grant_a), 32'h2);
        chk("t2_s_adr_m1", a_s.adr, 32'h1000_0000);
        chk("t2_s_dat_m1", a_s.dat_w, 32'hA5A5_0001);
        chk("t2_s_we_sel", 32'({a_s.we, a_s.sel}), 32'h13);
        expect_term(1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_0001);
        a_s.dat_r = 32'hCAFE_0001; a_s.ack = 1'b1;
        tick();
        a_s.ack = 1'b0;
        a_m1.cyc = 1'b0; a_m1.stb = 1'b0;
        tick();
        chk("t2_end_idle", 32'(grant_a), 32'h0);

        // Both masters requesting: six alternating single-write tenures
        a_m0.adr = 32'h3000_0000; a_m0.dat_w = 32'h0000_0100; a_m0.we = 1'b1; a_m0.sel = 4'h3;
        a_m1.adr = 32'h4000_0000; a_m1.dat_w = 32'h0000_0200; a_m1.we = 1'b1; a_m1.sel = 4'hC;
        a_m0.cyc = 1'b1; a_m0.stb = 1'b1;
        a_m1.cyc = 1'b1; a_m1.stb = 1'b1;
        for (int t = 0; t < 6; t++) begin
            owner = t[0];
            tick();
            k = 0;
            while (grant_a == 2'b00 && k < 8) begin
                tick();
                k++;
            end
            chk($sformatf("t3_grant_%0d", t), 32'(grant_a), owner ? 32'h2 : 32'h1);
            chk($sformatf("t3_sel_%0d", t), 32'(a_s.sel), owner ? 32'hC : 32'h3);
            chk($sformatf("t3_we_%0d", t), 32'(a_s.we), 32'h1);
            chk($sformatf("t3_adr_%0d", t), a_s.adr, owner ? 32'h4000_0000 : 32'h3000_0000);
            expect_term(1'b0, owner, 1'b1, 1'b0, 32'h0000_0A00 + 32'(t));
            a_s.dat_r = 32'h0000_0A00 + 32'(t); a_s.ack = 1'b1;
            tick();
            a_s.ack = 1'b0;
            if (owner) begin a_m1.cyc = 1'b0; a_m1.stb = 1'b0; end
            else       begin a_m0.cyc = 1'b0; a_m0.stb = 1'b0; end
            tick();
            if (owner) begin a_m1.cyc = 1'b1; a_m1.stb = 1'b1; end
            else       begin a_m0.cyc = 1'b1; a_m0.stb = 1'b1; end
        end
        a_m0.cyc = 1'b0; a_m0.stb = 1'b0;
        a_m1.cyc = 1'b0; a_m1.stb = 1'b0;
        tick();
        tick();
        chk("t3_end_idle", 32'(grant_a), 32'h0);

        // Watchdog (TIMEOUT=8): m1 write never acked, m0 waiting behind it
        a_s.dat_r = 32'h0;
        a_m1.adr = 32'h5000_0000; a_m1.dat_w = 32'h0000_0077; a_m1.we = 1'b1; a_m1.sel = 4'hF;
        a_m1.cyc = 1'b1; a_m1.stb = 1'b1;
        tick();
        chk("t4_grant_m1", 32'(grant_a), 32'h2);
        expect_term(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        a_m0.adr = 32'h2000_000C; a_m0.we = 1'b0; a_m0.sel = 4'hF;
        a_m0.cyc = 1'b1; a_m0.stb = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        chk("t4_no_err_s6", 32'(a_m1.err), 32'h0);
        tick();
        chk("t4_err_s7", 32'(a_m1.err), 32'h1);
        chk("t4_m0_err_s7", 32'(a_m0.err), 32'h0);
        tick();
        chk("t4_err_pulse_end", 32'(a_m1.err), 32'h0);
        a_m1.cyc = 1'b0; a_m1.stb = 1'b0;
        tick();
        chk("t4_idle", 32'(grant_a), 32'h0);
        tick();
        chk("t4_grant_m0", 32'(grant_a), 32'h1);
        chk("t4_s_adr_m0", a_s.adr, 32'h2000_000C);
        expect_term(1'b0, 1'b0, 1'b1, 1'b0, 32'h600D_0000);
        a_s.dat_r = 32'h600D_0000; a_s.ack = 1'b1;
        tick();
        a_s.ack = 1'b0;
        a_m0.cyc = 1'b0; a_m0.stb = 1'b0;
        tick();
        chk("t4_end_idle", 32'(grant_a), 32'h0);

        // Reset in the middle of an m0 burst
        a_m0.adr = 32'h2000_0010; a_m0.we = 1'b0; a_m0.sel = 4'hF;
        a_m0.cyc = 1'b1; a_m0.stb = 1'b1;
        tick();
        chk("t5_grant", 32'(grant_a), 32'h1);
        expect_term(1'b0, 1'b0, 1'b1, 1'b0, 32'h1111_0001);
        a_s.dat_r = 32'h1111_0001; a_s.ack = 1'b1;
        tick();
        expect_term(1'b0, 1'b0, 1'b1, 1'b0, 32'h1111_0002);
        a_s.dat_r = 32'h1111_0002;
        tick();
        a_s.dat_r = 32'h1111_0003;
        rst_a_n = 1'b0;
        #1;
        chk("t5_rst_s_cyc", 32'(a_s.cyc), 32'h0);
        chk("t5_rst_grant", 32'(grant_a), 32'h0);
        chk("t5_rst_m0_ack", 32'(a_m0.ack), 32'h0);
        chk("t5_rst_m0_dat", a_m0.dat_r, 32'h0);
        tick();
        chk("t5_rst_hold", 32'(grant_a), 32'h0);
        rst_a_n = 1'b1;
        a_s.ack = 1'b0;
        tick();
        chk("t5_regrant", 32'(grant_a), 32'h1);
        expect_term(1'b0, 1'b0, 1'b1, 1'b0, 32'h1111_0004);
        a_s.dat_r = 32'h1111_0004; a_s.ack = 1'b1;
        tick();
        a_s.ack = 1'b0;
        a_m0.cyc = 1'b0; a_m0.stb = 1'b0;
        tick();
        tick();
        chk("t5_end_idle", 32'(grant_a), 32'h0);

        // Watchdog disabled (TIMEOUT=0): 1000-cycle stall, then ack forwarded
        b_m0.adr = 32'h2000_0020; b_m0.we = 1'b0; b_m0.sel = 4'hF;
        b_m0.cyc = 1'b1; b_m0.stb = 1'b1;
        tick();
        chk("t6_grant", 32'(grant_b), 32'h1);
        errs = 0;
        for (int i = 1; i < 1000; i++) begin
            tick();
            if (b_m0.err) errs++;
        end
        tick();
        if (b_m0.err) errs++;
        chk("t6_no_err", 32'(errs), 32'h0);
        chk("t6_still_granted", 32'(grant_b), 32'h1);
        expect_term(1'b1, 1'b0, 1'b1, 1'b0, 32'hBEEF_1000);
        b_s.dat_r = 32'hBEEF_1000; b_s.ack = 1'b1;
        tick();
        b_s.ack = 1'b0;
        b_m0.cyc = 1'b0; b_m0.stb = 1'b0;
        tick();
        tick();
        chk("t6_end_idle", 32'(grant_b), 32'h0);

        tick();
        chk("scoreboard_drain", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_arbiter_2m
